// File: rtl/uart_ctrl.sv
// uart_ctrl: pops RX FIFO bytes into a DEPTH-byte history (newest first), optionally echoes
// each byte, and replays the history oldest-first on send_tick; TX pushes stall on tx_full.
module uart_ctrl #(
   parameter int DEPTH = 4,
   parameter bit ECHO  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx_empty,
   input  logic [7:0]             r_data,
   output logic                   rd_uart,
   input  logic                   tx_full,
   output logic [7:0]             w_data,
   output logic                   wr_uart,
   input  logic                   send_tick,
   output logic [3:0]             hex0,
   output logic [3:0]             hex1,
   output logic [3:0]             hex2,
   output logic [3:0]             hex3,
   output logic [$clog2(DEPTH):0] count,
   output logic                   busy
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   typedef enum logic [1:0] {S_IDLE, S_ECHO, S_SEND} state_t;

   state_t        state;
   logic [7:0]    hist [DEPTH];
   logic [IW-1:0] idx;
   logic [7:0]    echo_byte;
   logic          send_go;

   // A send request beats a pending receive byte in the same cycle.
   assign send_go = send_tick && (count != '0);

   always_comb begin
      rd_uart = 1'b0;
      wr_uart = 1'b0;
      w_data  = 8'h00;
      if (!rst) begin
         case (state)
            S_IDLE: rd_uart = !send_go && !rx_empty;
            S_ECHO: if (!tx_full) begin
               wr_uart = 1'b1;
               w_data  = echo_byte;
            end
            S_SEND: if (!tx_full) begin
               wr_uart = 1'b1;
               w_data  = hist[idx];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         count     <= '0;
         idx       <= '0;
         echo_byte <= 8'h00;
         for (int i = 0; i < DEPTH; i++) hist[i] <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (send_go) begin
                  state <= S_SEND;
                  idx   <= IW'(count - CW'(1));
               end else if (!rx_empty) begin
                  for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
                  hist[0]   <= r_data;
                  echo_byte <= r_data;
                  if (count != CW'(DEPTH)) count <= count + CW'(1);
                  if (ECHO) state <= S_ECHO;
               end
            end
            S_ECHO: if (!tx_full) state <= S_IDLE;
            S_SEND: if (!tx_full) begin
               if (idx == '0) state <= S_IDLE;
               else           idx   <= idx - IW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);
   assign hex0 = hist[0][3:0];
   assign hex1 = hist[0][7:4];
   assign hex2 = hist[1][3:0];
   assign hex3 = hist[1][7:4];

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: a receive-only instance (0) and an echo instance (1) checked every cycle
// against a queue-based model, plus vector tables and directed corner-case sequences.
module tb_uart_ctrl;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_empty  [2];
   logic [7:0]    r_data    [2];
   logic          rd_uart   [2];
   logic          tx_full   [2];
   logic [7:0]    w_data    [2];
   logic          wr_uart   [2];
   logic          send_tick [2];
   logic [3:0]    hex0 [2], hex1 [2], hex2 [2], hex3 [2];
   logic [CW-1:0] count [2];
   logic          busy  [2];

   uart_ctrl #(.DEPTH(DEPTH), .ECHO(1'b0)) u_rx (
      .clk(clk), .rst(rst), .rx_empty(rx_empty[0]), .r_data(r_data[0]), .rd_uart(rd_uart[0]),
      .tx_full(tx_full[0]), .w_data(w_data[0]), .wr_uart(wr_uart[0]), .send_tick(send_tick[0]),
      .hex0(hex0[0]), .hex1(hex1[0]), .hex2(hex2[0]), .hex3(hex3[0]), .count(count[0]), .busy(busy[0]));

   uart_ctrl #(.DEPTH(DEPTH), .ECHO(1'b1)) u_echo (
      .clk(clk), .rst(rst), .rx_empty(rx_empty[1]), .r_data(r_data[1]), .rd_uart(rd_uart[1]),
      .tx_full(tx_full[1]), .w_data(w_data[1]), .wr_uart(wr_uart[1]), .send_tick(send_tick[1]),
      .hex0(hex0[1]), .hex1(hex1[1]), .hex2(hex2[1]), .hex3(hex3[1]), .count(count[1]), .busy(busy[1]));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Environment RX FIFO contents, model history (newest at [0]), pending replay bytes, TX log.
   logic [7:0] rxq   [2][$];
   logic [7:0] hq    [2][$];
   logic [7:0] sendq [2][$];
   logic [7:0] txlog [2][$];
   int         txcyc [2][$];
   bit         echo_pend [2];
   logic [7:0] echo_b    [2];
   bit         e_rd [2], e_wr [2], e_go [2];
   logic [7:0] e_wd [2];

   typedef struct {
      int         k;
      bit         push;
      logic [7:0] b;
      bit         tick;
      bit         full;
      bit         rd;
      bit         wr;
      logic [7:0] wd;
      int         cnt;
      logic [15:0] hex;
   } vec_t;
   vec_t vt [15];

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
      end
   endtask

   task automatic cyc_begin();
      for (int k = 0; k < 2; k++) begin
         rx_empty[k] = (rxq[k].size() == 0);
         r_data[k]   = rx_empty[k] ? 8'($urandom) : rxq[k][0];
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         logic [7:0] b0, b1;
         e_rd[k] = 1'b0; e_wr[k] = 1'b0; e_go[k] = 1'b0; e_wd[k] = 8'h00;
         if (rst) begin
         end else if (echo_pend[k]) begin
            e_wr[k] = !tx_full[k];
            if (e_wr[k]) e_wd[k] = echo_b[k];
         end else if (sendq[k].size() > 0) begin
            e_wr[k] = !tx_full[k];
            if (e_wr[k]) e_wd[k] = sendq[k][0];
         end else begin
            e_go[k] = send_tick[k] && (hq[k].size() > 0);
            e_rd[k] = !e_go[k] && !rx_empty[k];
         end
         b0 = (hq[k].size() > 0) ? hq[k][0] : 8'h00;
         b1 = (hq[k].size() > 1) ? hq[k][1] : 8'h00;
         chk("rd_uart", k, rd_uart[k], e_rd[k]);
         chk("wr_uart", k, wr_uart[k], e_wr[k]);
         chk("w_data", k, w_data[k], e_wd[k]);
         chk("busy", k, busy[k], echo_pend[k] || (sendq[k].size() > 0));
         chk("count", k, count[k], hq[k].size());
         chk("hex", k, {hex3[k], hex2[k], hex1[k], hex0[k]}, {b1, b0});
         if (wr_uart[k] === 1'b1) begin
            txlog[k].push_back(w_data[k]);
            txcyc[k].push_back(cyc);
         end
      end
   endtask

   task automatic cyc_end();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            hq[k].delete();
            sendq[k].delete();
            echo_pend[k] = 1'b0;
         end else if (echo_pend[k]) begin
            if (e_wr[k]) echo_pend[k] = 1'b0;
         end else if (sendq[k].size() > 0) begin
            if (e_wr[k]) void'(sendq[k].pop_front());
         end else if (e_go[k]) begin
            for (int i = hq[k].size() - 1; i >= 0; i--) sendq[k].push_back(hq[k][i]);
         end else if (e_rd[k]) begin
            logic [7:0] b;
            b = rxq[k].pop_front();
            hq[k].push_front(b);
            if (hq[k].size() > DEPTH) void'(hq[k].pop_back());
            if (k == 1) begin
               echo_pend[k] = 1'b1;
               echo_b[k]    = b;
            end
         end
      end
      cyc++;
      #1;
      send_tick[0] = 1'b0;
      send_tick[1] = 1'b0;
   endtask

   task automatic cycle();
      cyc_begin();
      cyc_end();
   endtask

   initial begin
      int base0, base1;
      logic [7:0] gexp [4];
      gexp = '{8'h22, 8'h33, 8'h44, 8'h55};

      vt[0]  = '{1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 16'h0000};
      vt[1]  = '{1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 16'h00A5};
      vt[2]  = '{1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 16'h00A5};
      vt[3]  = '{0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 16'h0000};
      vt[4]  = '{0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1, 16'h0011};
      vt[5]  = '{0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2, 16'h1122};
      vt[6]  = '{0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3, 16'h2233};
      vt[7]  = '{0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4, 16'h3344};
      vt[8]  = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4, 16'h4455};
      vt[9]  = '{0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4, 16'h4455};
      vt[10] = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 4, 16'h4455};
      vt[11] = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 4, 16'h4455};
      vt[12] = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 4, 16'h4455};
      vt[13] = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 4, 16'h4455};
      vt[14] = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4, 16'h4455};

      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tx_full[k] = 1'b0; send_tick[k] = 1'b0; rx_empty[k] = 1'b1; r_data[k] = 8'h00;
         echo_pend[k] = 1'b0; echo_b[k] = 8'h00;
      end
      @(posedge clk);
      #1;
      cycle();
      rst = 1'b0;

      // Reset state, then a tick on an empty buffer must not transmit.
      cyc_begin();
      for (int k = 0; k < 2; k++) begin
         chk("rst_outs", k, {rd_uart[k], wr_uart[k], w_data[k], busy[k]}, 0);
         chk("rst_count", k, count[k], 0);
         chk("rst_hex", k, {hex3[k], hex2[k], hex1[k], hex0[k]}, 0);
      end
      cyc_end();
      base0 = txlog[0].size(); base1 = txlog[1].size();
      send_tick[0] = 1'b1; send_tick[1] = 1'b1;
      repeat (20) cycle();
      chk("empty_tick_wr", 0, txlog[0].size() - base0, 0);
      chk("empty_tick_wr", 1, txlog[1].size() - base1, 0);

      for (int i = 0; i < 15; i++) begin
         if (vt[i].push) rxq[vt[i].k].push_back(vt[i].b);
         send_tick[vt[i].k] = vt[i].tick;
         tx_full[vt[i].k]   = vt[i].full;
         cyc_begin();
         chk("vec_rd", vt[i].k, rd_uart[vt[i].k], vt[i].rd);
         chk("vec_wr", vt[i].k, wr_uart[vt[i].k], vt[i].wr);
         chk("vec_wd", vt[i].k, w_data[vt[i].k], vt[i].wd);
         chk("vec_count", vt[i].k, count[vt[i].k], vt[i].cnt);
         chk("vec_hex", vt[i].k, {hex3[vt[i].k], hex2[vt[i].k], hex1[vt[i].k], hex0[vt[i].k]}, vt[i].hex);
         cyc_end();
      end

      // Three tx_full cycles after the first replayed byte.
      base0 = txlog[0].size();
      send_tick[0] = 1'b1;
      cycle();
      cycle();
      tx_full[0] = 1'b1;
      repeat (3) cycle();
      tx_full[0] = 1'b0;
      repeat (4) cycle();
      chk("gap_pushes", 0, txlog[0].size() - base0, 4);
      for (int i = 0; i < 4; i++) chk("gap_byte", 0, txlog[0][base0+i], gexp[i]);
      chk("gap_len", 0, txcyc[0][base0+1] - txcyc[0][base0], 4);
      chk("gap_tail", 0, txcyc[0][base0+3] - txcyc[0][base0+1], 2);

      // Reset during the second cycle of a 4-byte replay.
      send_tick[0] = 1'b1;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      base0 = txlog[0].size();
      repeat (5) cycle();
      chk("rst_no_push", 0, txlog[0].size() - base0, 0);
      cyc_begin();
      chk("rst_mid_count", 0, count[0], 0);
      chk("rst_mid_hex", 0, {hex3[0], hex2[0], hex1[0], hex0[0]}, 0);
      chk("rst_mid_busy", 0, busy[0], 0);
      cyc_end();

      // Tick and a waiting byte together: replay first, later tick ignored, then the pop.
      rxq[0].push_back(8'hAA);
      cycle();
      base0 = txlog[0].size();
      rxq[0].push_back(8'hBB);
      send_tick[0] = 1'b1;
      cyc_begin();
      chk("tie_no_rd", 0, rd_uart[0], 0);
      cyc_end();
      send_tick[0] = 1'b1;
      cyc_begin();
      chk("tie_wr", 0, wr_uart[0], 1);
      chk("tie_wd", 0, w_data[0], 8'hAA);
      chk("tie_rd_busy", 0, rd_uart[0], 0);
      cyc_end();
      cyc_begin();
      chk("tie_pop", 0, rd_uart[0], 1);
      cyc_end();
      repeat (3) cycle();
      chk("tie_pushes", 0, txlog[0].size() - base0, 1);
      cyc_begin();
      chk("tie_count", 0, count[0], 2);
      chk("tie_hex", 0, {hex3[0], hex2[0], hex1[0], hex0[0]}, 16'hAABB);
      cyc_end();

      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < 2; k++) begin
            if (rxq[k].size() < 8 && $urandom_range(0, 2) == 0) rxq[k].push_back(8'($urandom));
            send_tick[k] = ($urandom_range(0, 15) == 0);
            tx_full[k]   = ($urandom_range(0, 3) == 0);
         end
         rst = ($urandom_range(0, 499) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
